// File: rtl/code_entry_lock_if.sv
// Keypad-side and comparator-side signals of the code-entry lock.
// The master drives keypad strobes; the slave (the lock controller) drives status.
interface code_entry_lock_if #(
    parameter int DIGITS    = 2,
    parameter int MAX_TRIES = 3
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);

    logic          digit_valid;
    logic [3:0]    digit;
    logic          enter;
    logic          clear;
    logic          is_equal;
    logic [W-1:0]  code_out;
    logic [CW-1:0] digit_cnt;
    logic [FW-1:0] fail_cnt;
    logic          unlock;
    logic          err;
    logic          alarm;
    logic          busy;

    modport master (
        output digit_valid, digit, enter, clear, is_equal,
        input  code_out, digit_cnt, fail_cnt, unlock, err, alarm, busy
    );

    modport slave (
        input  digit_valid, digit, enter, clear, is_equal,
        output code_out, digit_cnt, fail_cnt, unlock, err, alarm, busy
    );
endinterface

// File: rtl/code_entry_lock.sv
// Keypad code-entry controller: shifts BCD digits into the comparator's A operand,
// then sequences open / fail / lockout from the comparator's is_equal result.
module code_entry_lock #(
    parameter int DIGITS         = 2,
    parameter int MAX_TRIES      = 3,
    parameter int OPEN_CYCLES    = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    code_entry_lock_if.slave bus
);
    localparam int W    = 4 * DIGITS;
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int FW   = $clog2(MAX_TRIES + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          take_fail;
    logic          digit_ok;

    assign digit_ok = bus.digit_valid && (bus.digit <= 4'd9) && (cnt_q < CW'(DIGITS));

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        fail_d    = fail_q;
        timer_d   = timer_q;
        take_fail = 1'b0;
        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (bus.clear) begin
                    code_d  = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (bus.enter) begin
                    // enter in IDLE is consumed but does nothing
                    if (state_q == S_ENTRY) begin
                        if (cnt_q == CW'(DIGITS)) state_d = S_CHECK;
                        else                      take_fail = 1'b1;
                    end
                end else if (digit_ok) begin
                    code_d  = (code_q << 4) | W'(bus.digit);
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_ENTRY;
                end
            end
            S_CHECK: begin
                if (bus.is_equal) begin
                    fail_d  = '0;
                    timer_d = TW'(OPEN_CYCLES - 1);
                    state_d = S_OPEN;
                end else begin
                    take_fail = 1'b1;
                end
            end
            S_OPEN: begin
                if (timer_q == '0) begin
                    code_d  = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_FAIL: begin
                code_d  = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_d  = '0;
                    code_d  = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared failure path for a wrong comparison and an incomplete entry
        if (take_fail) begin
            if (int'(fail_q) + 1 >= MAX_TRIES) begin
                fail_d  = FW'(MAX_TRIES);
                timer_d = TW'(LOCKOUT_CYCLES - 1);
                state_d = S_LOCKOUT;
            end else begin
                fail_d  = fail_q + FW'(1);
                state_d = S_FAIL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    // Status flags decode straight from state so reset clears them without a clock edge
    assign bus.code_out  = code_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.unlock    = (state_q == S_OPEN);
    assign bus.err       = (state_q == S_FAIL);
    assign bus.alarm     = (state_q == S_LOCKOUT);
    assign bus.busy      = (state_q == S_CHECK) || (state_q == S_OPEN) ||
                           (state_q == S_FAIL)  || (state_q == S_LOCKOUT);
endmodule

// File: tb/tb_code_entry_lock.sv
// Bench for code_entry_lock with an 8-bit equality comparator against stored code 8'h42.
// Observed word layout: {code_out[7:0], digit_cnt[1:0], fail_cnt[1:0], unlock, err, alarm, busy}.
module tb_code_entry_lock;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    code_entry_lock_if #(.DIGITS(2), .MAX_TRIES(3)) bus ();
    assign bus.is_equal = (bus.code_out == 8'h42);

    code_entry_lock #(
        .DIGITS(2), .MAX_TRIES(3), .OPEN_CYCLES(8), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        logic [15:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] got;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [15:0] obs();
        return {bus.code_out, bus.digit_cnt, bus.fail_cnt, bus.unlock, bus.err, bus.alarm, bus.busy};
    endfunction

    function automatic logic [15:0] mk(input logic [7:0] c, input logic [1:0] n,
                                       input logic [1:0] f, input logic [3:0] fl);
        return {c, n, f, fl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        tick();
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    // Two digits then enter; returns one edge after CHECK was entered
    task automatic attempt(input logic [3:0] a, input logic [3:0] b);
        press(a);
        press(b);
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        sb.push_back('{"reset_hold", mk(8'h00, 2'd0, 2'd0, 4'b0000)});
        sb.push_back('{"reset_release", mk(8'h00, 2'd0, 2'd0, 4'b0000)});
        repeat (3) tick();
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        rst = 1'b0;
        tick();
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
    endtask

    task automatic test_open();
        int n;
        sb.push_back('{"open_entry", mk(8'h42, 2'd2, 2'd0, 4'b0000)});
        sb.push_back('{"open_check", mk(8'h42, 2'd2, 2'd0, 4'b0001)});
        sb.push_back('{"open_first", mk(8'h42, 2'd2, 2'd0, 4'b1001)});
        sb.push_back('{"open_cycles", 16'd8});
        sb.push_back('{"open_idle", mk(8'h00, 2'd0, 2'd0, 4'b0000)});
        press(4'd4);
        press(4'd2);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        tick();
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        n = 0;
        while (bus.unlock === 1'b1 && n < 40) begin n++; tick(); end
        got = 16'(n); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, got, e.v); end else $display("ok   %s: %0d", e.name, got);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
    endtask

    task automatic test_wrong_code();
        sb.push_back('{"wrong_err", mk(8'h13, 2'd2, 2'd1, 4'b0101)});
        sb.push_back('{"wrong_idle", mk(8'h00, 2'd0, 2'd1, 4'b0000)});
        attempt(4'd1, 4'd3);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        tick();
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
    endtask

    task automatic test_back_to_back_lockout();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.push_back('{"b2b_fail1", mk(8'h13, 2'd2, 2'd1, 4'b0101)});
        sb.push_back('{"b2b_fail2", mk(8'h55, 2'd2, 2'd2, 4'b0101)});
        sb.push_back('{"b2b_lockout", mk(8'h99, 2'd2, 2'd3, 4'b0011)});
        sb.push_back('{"b2b_alarm_cycles", 16'd16});
        sb.push_back('{"b2b_after", mk(8'h00, 2'd0, 2'd0, 4'b0000)});
        attempt(4'd1, 4'd3);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        tick();
        attempt(4'd5, 4'd5);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        tick();
        attempt(4'd9, 4'd9);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        n = 0;
        while (bus.alarm === 1'b1 && n < 60) begin
            n++;
            bus.digit_valid = 1'b1;
            bus.digit       = 4'(n % 10);
            bus.enter       = (n % 2 == 1);
            bus.clear       = (n % 5 == 0);
            tick();
        end
        bus.digit_valid = 1'b0;
        bus.enter       = 1'b0;
        bus.clear       = 1'b0;
        got = 16'(n); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, got, e.v); end else $display("ok   %s: %0d", e.name, got);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
    endtask

    task automatic test_digit_filter();
        sb.push_back('{"filter_bad_digit", mk(8'h04, 2'd1, 2'd0, 4'b0000)});
        sb.push_back('{"filter_full", mk(8'h42, 2'd2, 2'd0, 4'b0000)});
        sb.push_back('{"filter_clear", mk(8'h00, 2'd0, 2'd0, 4'b0000)});
        press(4'd4);
        press(4'd11);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        press(4'd2);
        press(4'd7);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
    endtask

    task automatic test_incomplete_enter();
        int n;
        sb.push_back('{"short_err", mk(8'h04, 2'd1, 2'd1, 4'b0101)});
        sb.push_back('{"short_idle", mk(8'h00, 2'd0, 2'd1, 4'b0000)});
        sb.push_back('{"short_then_open", mk(8'h42, 2'd2, 2'd0, 4'b1001)});
        press(4'd4);
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        tick();
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        attempt(4'd4, 4'd2);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        n = 0;
        while (bus.unlock === 1'b1 && n < 40) begin n++; tick(); end
    endtask

    task automatic test_clear_and_reset();
        sb.push_back('{"clr_pre_fail", mk(8'h13, 2'd2, 2'd1, 4'b0101)});
        sb.push_back('{"clr_beats_enter", mk(8'h00, 2'd0, 2'd1, 4'b0000)});
        sb.push_back('{"rst_open", mk(8'h42, 2'd2, 2'd0, 4'b1001)});
        sb.push_back('{"rst_async", mk(8'h00, 2'd0, 2'd0, 4'b0000)});
        attempt(4'd1, 4'd3);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        tick();
        press(4'd4);
        press(4'd2);
        bus.clear = 1'b1;
        bus.enter = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.enter = 1'b0;
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        attempt(4'd4, 4'd2);
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        tick();
        tick();
        rst = 1'b1;
        #1;
        got = obs(); e = sb.pop_front(); n_chk++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end else $display("ok   %s: %h", e.name, got);
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.enter       = 1'b0;
        bus.clear       = 1'b0;
        test_reset();
        test_open();
        test_wrong_code();
        test_back_to_back_lockout();
        test_digit_filter();
        test_incomplete_enter();
        test_clear_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
